// File: rtl/parking_lot_ctrl_multi.sv
// Multi-gate parking occupancy controller: one two-sensor direction FSM per lane feeding
// a shared saturating occupancy counter with programmable capacity.
module parking_lot_ctrl_multi #(
    parameter int LANES      = 2,
    parameter int CNT_W      = 3,
    parameter int CAPACITY   = 7,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LANES-1:0] sensor_a,
    input  logic [LANES-1:0] sensor_b,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic [LANES-1:0] in_evt,
    output logic [LANES-1:0] out_evt,
    output logic             ovf,
    output logic             unf
);

    localparam int PC_W  = $clog2(LANES + 1);
    localparam int SUM_W = CNT_W + PC_W + 1;
    localparam logic signed [SUM_W-1:0] CAP_S = SUM_W'(CAPACITY);
    localparam logic        [CNT_W-1:0] CAP_C = CNT_W'(CAPACITY);

    typedef enum logic [2:0] {IDLE, E1, E2, E3, X1, X2, X3} lane_state_t;

    logic [1:0]        ab_q    [LANES];
    lane_state_t       state_q [LANES];
    lane_state_t       state_d [LANES];
    logic [LANES-1:0]  in_d;
    logic [LANES-1:0]  out_d;

    logic [SUM_W-1:0]        ins;
    logic [SUM_W-1:0]        outs;
    logic signed [SUM_W-1:0] sum;
    logic [CNT_W-1:0]        count_d;
    logic                    ovf_d;
    logic                    unf_d;

    // Sensor codes are normalised to active-high {a,b} before the FSMs see them.
    always_ff @(posedge clk) begin
        // NOTE: registers are written with <= so every flop samples pre-edge values.
        for (int i = 0; i < LANES; i++) begin
            if (reset) ab_q[i] <= 2'b00;
            else       ab_q[i] <= {sensor_a[i], sensor_b[i]} ^ {2{ACTIVE_LOW}};
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (reset) state_q[i] <= IDLE;
            else       state_q[i] <= state_d[i];
        end
        if (reset) begin
            in_evt  <= '0;
            out_evt <= '0;
        end else begin
            in_evt  <= in_d;
            out_evt <= out_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latches are inferred.
        in_d  = '0;
        out_d = '0;
        for (int i = 0; i < LANES; i++) begin
            state_d[i] = IDLE;
            unique case (state_q[i])
                IDLE: begin
                    if (ab_q[i] == 2'b10)      state_d[i] = E1;
                    else if (ab_q[i] == 2'b01) state_d[i] = X1;
                end
                E1: begin
                    if (ab_q[i] == 2'b10)      state_d[i] = E1;
                    else if (ab_q[i] == 2'b11) state_d[i] = E2;
                end
                E2: begin
                    if (ab_q[i] == 2'b11)      state_d[i] = E2;
                    else if (ab_q[i] == 2'b01) state_d[i] = E3;
                    else if (ab_q[i] == 2'b10) state_d[i] = E1;
                end
                E3: begin
                    if (ab_q[i] == 2'b01)      state_d[i] = E3;
                    else if (ab_q[i] == 2'b11) state_d[i] = E2;
                    else if (ab_q[i] == 2'b00) in_d[i]    = 1'b1;
                end
                X1: begin
                    if (ab_q[i] == 2'b01)      state_d[i] = X1;
                    else if (ab_q[i] == 2'b11) state_d[i] = X2;
                end
                X2: begin
                    if (ab_q[i] == 2'b11)      state_d[i] = X2;
                    else if (ab_q[i] == 2'b10) state_d[i] = X3;
                    else if (ab_q[i] == 2'b01) state_d[i] = X1;
                end
                X3: begin
                    if (ab_q[i] == 2'b10)      state_d[i] = X3;
                    else if (ab_q[i] == 2'b11) state_d[i] = X2;
                    else if (ab_q[i] == 2'b00) out_d[i]   = 1'b1;
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    // All lanes are netted in one signed sum before clamping, so in+out at a limit is a no-op.
    always_comb begin
        ins  = '0;
        outs = '0;
        for (int i = 0; i < LANES; i++) begin
            ins  = ins  + SUM_W'(in_evt[i]);
            outs = outs + SUM_W'(out_evt[i]);
        end
        sum     = $signed(SUM_W'(count) + ins - outs);
        count_d = sum[CNT_W-1:0];
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (sum[SUM_W-1]) begin
            count_d = '0;
            unf_d   = 1'b1;
        end else if (sum > CAP_S) begin
            count_d = CAP_C;
            ovf_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            count <= count_d;
            ovf   <= ovf_d;
            unf   <= unf_d;
        end
    end

    assign full  = (count == CAP_C);
    assign empty = (count == '0);

endmodule
